// File: rtl/piezo_pkg.sv
// Shared note constants, alert/state enums and the six-entry note table for the
// piezo alert scheduler.
package piezo_pkg;

   localparam logic [13:0] G6 = 14'd15944;
   localparam logic [13:0] C7 = 14'd11944;
   localparam logic [13:0] E7 = 14'd9480;
   localparam logic [13:0] G7 = 14'd7972;

   localparam logic [25:0] D23    = 26'd8388608;
   localparam logic [25:0] D23_22 = 26'd12582912;
   localparam logic [25:0] D22    = 26'd4194304;
   localparam logic [25:0] D25    = 26'd33554432;

   typedef enum logic [1:0] {
      NONE    = 2'd0,
      FANFARE = 2'd1,
      REVERSE = 2'd2,
      LOOP    = 2'd3
   } alert_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      PLAY  = 2'd2
   } sched_state_t;

   typedef struct packed {
      logic [13:0] half_per;
      logic [25:0] dur;
   } note_t;

   // Table position follows the fanfare order; the reverse melody reads it back to front.
   function automatic note_t note_table(input logic [2:0] pos);
      note_t n;
      case (pos)
         3'd0:    n = '{half_per: G6, dur: D23};
         3'd1:    n = '{half_per: C7, dur: D23};
         3'd2:    n = '{half_per: E7, dur: D23};
         3'd3:    n = '{half_per: G7, dur: D23_22};
         3'd4:    n = '{half_per: E7, dur: D22};
         default: n = '{half_per: G7, dur: D25};
      endcase
      return n;
   endfunction

endpackage

// File: rtl/piezo_alert_sched_if.sv
// Note-command handshake between the alert scheduler and the tone player.
interface piezo_alert_sched_if;

   logic        cmd_vld;
   logic        cmd_rdy;
   logic [13:0] cmd_half_per;
   logic [25:0] cmd_dur;
   logic        cmd_last;
   logic        tone_done;

   modport master (
      output cmd_vld,
      output cmd_half_per,
      output cmd_dur,
      output cmd_last,
      input  cmd_rdy,
      input  tone_done
   );

   modport slave (
      input  cmd_vld,
      input  cmd_half_per,
      input  cmd_dur,
      input  cmd_last,
      output cmd_rdy,
      output tone_done
   );

endinterface

// File: rtl/piezo_rpt_timer.sv
// Repeat hold-off timer: after clr, rpt_ok stays low for the full hold-off period,
// then rises and the counter parks at zero until the next clr.
module piezo_rpt_timer #(
   parameter bit          FAST_SIM   = 1'b0,
   parameter int unsigned REPEAT_CYC = 150_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   output logic rpt_ok
);

   localparam int unsigned TERM_CYC = FAST_SIM ? (REPEAT_CYC / 64) : REPEAT_CYC;
   localparam logic [27:0] TERM_CNT = 28'(TERM_CYC - 1);

   logic [27:0] cnt;

   // A clr arriving on the terminal-count cycle wins, so the hold-off restarts cleanly.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt    <= '0;
         rpt_ok <= 1'b1;
      end else if (clr) begin
         cnt    <= '0;
         rpt_ok <= 1'b0;
      end else if (!rpt_ok) begin
         if (cnt == TERM_CNT) begin
            cnt    <= '0;
            rpt_ok <= 1'b1;
         end else begin
            cnt <= cnt + 28'd1;
         end
      end
   end

endmodule

// File: rtl/piezo_alert_sched.sv
// Alert scheduler: picks a melody by request priority and feeds its notes one at a
// time to the tone player, waiting for tone_done between notes.
module piezo_alert_sched
   import piezo_pkg::*;
#(
   parameter bit          FAST_SIM   = 1'b0,
   parameter int unsigned REPEAT_CYC = 150_000_000
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       too_fast,
   input  logic                       batt_low,
   input  logic                       en_steer,
   piezo_alert_sched_if.master        cmd,
   output logic                       busy,
   output logic [1:0]                 alert_id
);

   sched_state_t state;
   alert_t       melody;
   logic [2:0]   idx;

   logic         rpt_ok;
   logic         rpt_clr;
   logic         load;
   logic         go_idle;
   alert_t       load_mel;
   logic [2:0]   load_idx;
   note_t        load_note;
   logic         load_last;

   function automatic note_t melody_note(input alert_t m, input logic [2:0] i);
      note_t n;
      n = note_table((m == REVERSE) ? (3'd5 - i) : i);
      if (FAST_SIM) n.dur = n.dur >> 6;
      return n;
   endfunction

   piezo_rpt_timer #(
      .FAST_SIM   (FAST_SIM),
      .REPEAT_CYC (REPEAT_CYC)
   ) u_rpt_timer (
      .clk    (clk),
      .rst    (rst),
      .clr    (rpt_clr),
      .rpt_ok (rpt_ok)
   );

   // Next-note decision. The loop always plays whole G6-C7-E7 passes: too_fast is
   // consulted at the E7, so dropping it mid-pass lets the pass finish with cmd_last.
   always_comb begin
      load     = 1'b0;
      go_idle  = 1'b0;
      rpt_clr  = 1'b0;
      load_mel = melody;
      load_idx = 3'd0;
      case (state)
         IDLE: begin
            if (too_fast) begin
               load     = 1'b1;
               load_mel = LOOP;
            end else if (batt_low && rpt_ok) begin
               load     = 1'b1;
               load_mel = REVERSE;
               rpt_clr  = 1'b1;
            end else if (en_steer && rpt_ok) begin
               load     = 1'b1;
               load_mel = FANFARE;
               rpt_clr  = 1'b1;
            end
         end
         PLAY: begin
            if (cmd.tone_done) begin
               if (melody != LOOP && too_fast) begin
                  load     = 1'b1;
                  load_mel = LOOP;
               end else if (melody == LOOP) begin
                  if (idx != 3'd2) begin
                     load     = 1'b1;
                     load_idx = idx + 3'd1;
                  end else if (too_fast) begin
                     load = 1'b1;
                  end else begin
                     go_idle = 1'b1;
                  end
               end else if (idx != 3'd5) begin
                  load     = 1'b1;
                  load_idx = idx + 3'd1;
               end else begin
                  go_idle = 1'b1;
               end
            end
         end
         default: ;
      endcase
      load_note = melody_note(load_mel, load_idx);
      load_last = (load_mel == LOOP) ? ((load_idx == 3'd2) && !too_fast)
                                     : (load_idx == 3'd5);
   end

   // Command fields are only written on a load, so they stay frozen through an ISSUE stall.
   always_ff @(posedge clk) begin
      if (rst) begin
         state            <= IDLE;
         melody           <= NONE;
         idx              <= 3'd0;
         cmd.cmd_vld      <= 1'b0;
         cmd.cmd_half_per <= '0;
         cmd.cmd_dur      <= '0;
         cmd.cmd_last     <= 1'b0;
         busy             <= 1'b0;
         alert_id         <= 2'd0;
      end else if (load) begin
         state            <= ISSUE;
         melody           <= load_mel;
         idx              <= load_idx;
         cmd.cmd_vld      <= 1'b1;
         cmd.cmd_half_per <= load_note.half_per;
         cmd.cmd_dur      <= load_note.dur;
         cmd.cmd_last     <= load_last;
         busy             <= 1'b1;
         alert_id         <= load_mel;
      end else if (go_idle) begin
         state            <= IDLE;
         melody           <= NONE;
         idx              <= 3'd0;
         cmd.cmd_vld      <= 1'b0;
         cmd.cmd_half_per <= '0;
         cmd.cmd_dur      <= '0;
         cmd.cmd_last     <= 1'b0;
         busy             <= 1'b0;
         alert_id         <= 2'd0;
      end else if (state == ISSUE && cmd.cmd_rdy) begin
         state       <= PLAY;
         cmd.cmd_vld <= 1'b0;
      end
   end

endmodule

// File: doc/piezo_alert_sched.md
Name: piezo_alert_sched

Overview:
Scheduler for the piezo tone player. Arbitrates three alert requesters (too_fast, batt_low, en_steer) and walks the chosen melody from a note table. Issues one note command at a time to the tone player over a valid/ready handshake, then waits for its done pulse. Enforces the 3 s repeat hold-off for the non-urgent melodies.

Parameters:
FAST_SIM, 0, 1 = note durations and repeat period divided by 64 for simulation
REPEAT_CYC, 150_000_000, clk cycles of repeat hold-off (3 s at 50 MHz)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
too_fast  in  1  level request; highest priority
batt_low  in  1  level request; middle priority
en_steer  in  1  level request; lowest priority
cmd_vld  out  1  note command valid
cmd_rdy  in  1  tone player accepts command
cmd_half_per  out  14  half-period of note in clk cycles
cmd_dur  out  26  note duration in clk cycles
cmd_last  out  1  final note of current melody
tone_done  in  1  1-cycle pulse: current note finished
busy  out  1  melody in progress
alert_id  out  2  0 none, 1 fanfare, 2 reverse, 3 too_fast loop

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, rst.
- Reset values: cmd_vld=0, cmd_half_per=0, cmd_dur=0, cmd_last=0, busy=0, alert_id=0, state=IDLE, note index=0, rpt_ok=1, repeat counter=0. Reset mid-melody aborts immediately with the same values.
- Melodies, as index: half_per/dur:
  - FANFARE: 0 G6 15944/2^23, 1 C7 11944/2^23, 2 E7 9480/2^23, 3 G7 7972/(2^23+2^22), 4 E7 9480/2^22, 5 G7 7972/2^25.
  - REVERSE: same 6 entries in order 5..0.
  - LOOP (too_fast): indices 0,1,2, then repeat from 0.
- FAST_SIM=1: cmd_dur = table value >>6; hold-off terminal count = REPEAT_CYC/64. cmd_half_per is unchanged.
- FSM states: IDLE, ISSUE, PLAY.
- IDLE -> ISSUE, index 0, next cycle, using the first matching request:
  - too_fast: LOOP. Ignores rpt_ok.
  - batt_low && rpt_ok: REVERSE. Clears rpt_ok and restarts the counter.
  - en_steer && rpt_ok: FANFARE. Clears rpt_ok and restarts the counter.
- ISSUE: cmd_vld=1 and fields valid. Fields held stable while cmd_vld && !cmd_rdy. On cmd_vld&&cmd_rdy go to PLAY and drop cmd_vld the next cycle.
- PLAY: on tone_done:
  - too_fast=1 and melody != LOOP: preempt. Switch to LOOP, index 0, ISSUE.
  - LOOP and too_fast=1: index wraps 2->0, ISSUE.
  - LOOP and too_fast=0: IDLE.
  - Otherwise, if index<5: index+1, ISSUE.
  - Otherwise (index 5): IDLE.
- tone_done outside PLAY is ignored. Request changes inside PLAY take effect only at tone_done.
- cmd_last=1 on index 5 of FANFARE/REVERSE, and on index 2 of LOOP when too_fast=0 at issue.
- busy=1 in ISSUE/PLAY. alert_id is valid while busy and 0 in IDLE.
- Hold-off counter:
  - 28-bit; increments every cycle while rpt_ok=0.
  - At terminal count: rpt_ok<=1, counter<=0.
  - Start of FANFARE/REVERSE in the same cycle as terminal count: the clear wins and the counter restarts at 0.
  - Saturates idle (holds 0) while rpt_ok=1.
  - LOOP does not touch the timer.

Decomposition:
- piezo_pkg holds:
  - note half-period localparams G6, C7, E7, G7;
  - duration localparams D23, D23_22, D22, D25;
  - alert_t enum (NONE, FANFARE, REVERSE, LOOP);
  - sched_state_t enum;
  - a 6-entry note table function indexed by position.
- One sub-module, piezo_rpt_timer, holds the hold-off counter and rpt_ok. Inputs: clk, rst, clr. Output: rpt_ok. Parameter: FAST_SIM.

Test Plan:
- After rst, en_steer=1, cmd_rdy=1, tone_done pulsed 1 cycle after each accept. Expect 6 commands: 15944, 11944, 9480, 7972, 9480, 7972 with cmd_last only on the 6th; then IDLE. A second en_steer is ignored until REPEAT_CYC cycles elapse.
- batt_low=1 after reset: half_per sequence 7972, 9480, 7972, 9480, 11944, 15944 with alert_id=2. Durations reversed, first = 2^25.
- too_fast held through 9 tone_done pulses: half_per repeats 15944, 11944, 9480 x3. Drop too_fast before the 9th issue: cmd_last=1 on that E7, then IDLE.
- too_fast raised during FANFARE index 3: G7 completes; next command is 15944, alert_id=3. Timer is not reset.
- cmd_rdy low for 5 cycles in ISSUE: cmd_vld and fields are stable all 5 cycles; exactly one command is accepted.
- rst pulsed in PLAY: next cycle cmd_vld=0, busy=0, rpt_ok=1. FAST_SIM=1: the first FANFARE cmd_dur = 2^17.
